control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle Moore control FSM that sits directly upstream of the datapath.
- Sequences fetch / operand-load / execute / writeback / PC-advance by driving the datapath strobes: pc_load, reg_load_a, reg_load_b, reg_load_c and ram_we.
- Decodes the current opcode presented by RAM at address PC.
- Also provides a program-load path from IDLE, plus run status and a retired-instruction counter.

Parameters:
- EXEC_CYCLES, 1: cycles spent in EXEC, covering the clocked ALU latency; legal range 1..15.
- NOP_OPCODE, 8'h00: no-operation encoding.
- HLT_OPCODE, 8'hFF: halt encoding.
- ALU_MAX, 8'h7F: highest opcode of the ALU class; the ALU class is 8'h01..ALU_MAX.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  8  opcode from RAM at address PC.
- start  in  1  begin execution; sampled in IDLE only.
- prog_we  in  1  program-load write request; honoured in IDLE only.
- step  in  1  single-step advance; used only with CU_SINGLE_STEP_EN.
- pc_load  out  1  PC advance strobe.
- reg_load_a  out  1  load register A from operand 1.
- reg_load_b  out  1  load register B from operand 2.
- reg_load_c  out  1  store ALU result to register C.
- ram_we  out  1  RAM write enable.
- busy  out  1  high in every state except IDLE, HALT and ERROR.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.
- instr_count  out  16  retired-instruction count.

Behaviour:
- reset low: state becomes IDLE immediately, even mid-instruction. All outputs go to 0, including instr_count, EXEC counter and opcode_q.
- States: IDLE, FETCH, LOAD_OPS, EXEC, WRITE, ADVANCE, HALT, ERROR, plus STEP_WAIT when the feature is enabled.
- Strobes are 1 exactly during the named state's cycle, decoded from the state register only:
  - reg_load_a = reg_load_b = 1 in LOAD_OPS.
  - reg_load_c = 1 in WRITE.
  - pc_load = 1 in ADVANCE.
- IDLE, prog_we=1: ram_we=1 and pc_load=1 in the same cycle (combinational from prog_we AND state==IDLE). Each asserted cycle writes one byte and advances the PC.
- IDLE, prog_we=0, start=1: next state FETCH.
- IDLE, prog_we=1, start=1 together: prog_we wins and start is ignored.
- FETCH: opcode is sampled into opcode_q at the end of the cycle. Decode:
  - NOP_OPCODE → ADVANCE.
  - HLT_OPCODE → HALT.
  - 8'h01..ALU_MAX → LOAD_OPS.
  - Anything else → ERROR.
- LOAD_OPS → EXEC. EXEC lasts exactly EXEC_CYCLES cycles (down-counter), then → WRITE. WRITE → ADVANCE.
- ADVANCE → FETCH, or → STEP_WAIT when the feature is enabled. instr_count increments in ADVANCE.
- HALT and ERROR are terminal:
  - start and prog_we are ignored; only reset exits.
  - Entering HALT increments instr_count once. ERROR does not increment it.
- instr_count saturates at 16'hFFFF; no wrap.
- ram_we is never asserted outside IDLE.
- Instruction latency: ALU op = 4 + EXEC_CYCLES cycles; NOP = 2 cycles.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- When defined:
  - ADVANCE → STEP_WAIT.
  - STEP_WAIT holds with busy=1 and all strobes 0.
  - A 1-cycle-or-longer step=1 moves to FETCH on the first cycle step is sampled high.
  - step must return low and rise again to release the next instruction; edge-detected internally.
- When undefined:
  - No STEP_WAIT state; ADVANCE → FETCH directly.
  - The step port exists but is ignored.

Test Plan:
- Reset: reset=0 mid-EXEC → within the same cycle all strobes=0, busy=0, instr_count=0. After reset=1, state is IDLE.
- Program load: in IDLE, prog_we=1 for 3 cycles with start=1 concurrently → ram_we and pc_load each high exactly 3 cycles, no FETCH entered, busy stays 0.
- ALU op: opcode=8'h01 constant, EXEC_CYCLES=1, start pulse → reg_load_a/b high on cycle 2, reg_load_c high on cycle 4, pc_load high on cycle 5, FETCH again on cycle 6, instr_count=1.
- NOP then HLT: opcode 8'h00 then 8'hFF → pc_load once, then halted=1, busy=0, instr_count=2. start pulses afterwards have no effect.
- Illegal: opcode=8'h80 at FETCH → err=1 next cycle, no strobes ever again, instr_count unchanged.
- Single-step (CU_SINGLE_STEP_EN defined): two NOPs → after the first ADVANCE, FETCH is not re-entered until step rises. Holding step high for 10 cycles releases exactly one instruction.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle Moore control FSM sequencing fetch/load/exec/write/advance strobes for the datapath.
// Optional CU_SINGLE_STEP_EN adds a STEP_WAIT state released by a rising edge on step.
module control_unit #(
  parameter int unsigned EXEC_CYCLES = 1,
  parameter logic [7:0]  NOP_OPCODE  = 8'h00,
  parameter logic [7:0]  HLT_OPCODE  = 8'hFF,
  parameter logic [7:0]  ALU_MAX     = 8'h7F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  opcode,
  input  logic        start,
  input  logic        prog_we,
  input  logic        step,
  output logic        pc_load,
  output logic        reg_load_a,
  output logic        reg_load_b,
  output logic        reg_load_c,
  output logic        ram_we,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [15:0] instr_count
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_LOAD_OPS  = 4'd2;
  localparam logic [3:0] S_EXEC      = 4'd3;
  localparam logic [3:0] S_WRITE     = 4'd4;
  localparam logic [3:0] S_ADVANCE   = 4'd5;
  localparam logic [3:0] S_HALT      = 4'd6;
  localparam logic [3:0] S_ERROR     = 4'd7;
  localparam logic [3:0] S_STEP_WAIT = 4'd8;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] exec_cnt;
  logic [7:0] opcode_q;
  logic       prog_wr;
  logic       count_bump;

  function automatic logic is_alu(input logic [7:0] op);
    return (op >= 8'h01) && (op <= ALU_MAX);
  endfunction

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  logic step_rise;
  assign step_rise = step && !step_q;
`else
  logic step_unused;
  assign step_unused = step;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (!prog_we && start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (opcode == NOP_OPCODE)      state_nxt = S_ADVANCE;
        else if (opcode == HLT_OPCODE) state_nxt = S_HALT;
        else if (is_alu(opcode))       state_nxt = S_LOAD_OPS;
        else                           state_nxt = S_ERROR;
      end
      // opcode_q re-checked so a corrupted latch cannot drive a bogus execute
      S_LOAD_OPS: state_nxt = is_alu(opcode_q) ? S_EXEC : S_ERROR;
      S_EXEC:     if (exec_cnt == 4'd0) state_nxt = S_WRITE;
      S_WRITE:    state_nxt = S_ADVANCE;
`ifdef CU_SINGLE_STEP_EN
      S_ADVANCE:   state_nxt = S_STEP_WAIT;
      S_STEP_WAIT: if (step_rise) state_nxt = S_FETCH;
`else
      S_ADVANCE:   state_nxt = S_FETCH;
`endif
      S_HALT:     state_nxt = S_HALT;
      S_ERROR:    state_nxt = S_ERROR;
      default:    state_nxt = S_ERROR;
    endcase
  end

  // HALT counts as a retired instruction; ERROR does not
  assign count_bump = (state == S_ADVANCE) ||
                      ((state == S_FETCH) && (state_nxt == S_HALT));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      exec_cnt    <= 4'd0;
      opcode_q    <= 8'h00;
      instr_count <= 16'h0000;
`ifdef CU_SINGLE_STEP_EN
      step_q      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) opcode_q <= opcode;
      if (state == S_LOAD_OPS)
        exec_cnt <= EXEC_LOAD;
      else if ((state == S_EXEC) && (exec_cnt != 4'd0))
        exec_cnt <= exec_cnt - 4'd1;
      if (count_bump && (instr_count != 16'hFFFF))
        instr_count <= instr_count + 16'd1;
`ifdef CU_SINGLE_STEP_EN
      step_q <= step;
`endif
    end
  end

  // reset gates the combinational program-load path so outputs are quiet in reset
  assign prog_wr    = reset && prog_we && (state == S_IDLE);
  assign ram_we     = prog_wr;
  assign pc_load    = (state == S_ADVANCE) || prog_wr;
  assign reg_load_a = (state == S_LOAD_OPS);
  assign reg_load_b = (state == S_LOAD_OPS);
  assign reg_load_c = (state == S_WRITE);
  assign halted     = (state == S_HALT);
  assign err        = (state == S_ERROR);
  assign busy       = (state != S_IDLE) && (state != S_HALT) && (state != S_ERROR);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, program load, ALU op timing, NOP/HLT, illegal opcode, stepping.
`timescale 1ns/1ps
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  opcode;
  logic        start;
  logic        prog_we;
  logic        step;
  logic        pc_load;
  logic        reg_load_a;
  logic        reg_load_b;
  logic        reg_load_c;
  logic        ram_we;
  logic        busy;
  logic        halted;
  logic        err;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  control_unit dut (
    .clock(clock), .reset(reset), .opcode(opcode), .start(start),
    .prog_we(prog_we), .step(step), .pc_load(pc_load),
    .reg_load_a(reg_load_a), .reg_load_b(reg_load_b), .reg_load_c(reg_load_c),
    .ram_we(ram_we), .busy(busy), .halted(halted), .err(err),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // packs all single-bit outputs: {pc_load,a,b,c,ram_we,busy,halted,err}
  function automatic logic [7:0] outs();
    return {pc_load, reg_load_a, reg_load_b, reg_load_c, ram_we, busy, halted, err};
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; step = 1'b0; opcode = 8'h00;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; prog_we = 1'b1; step = 1'b0; opcode = 8'h01;
    #3;
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), 8'h00); end
    checks++;
    if (instr_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h exp 0000", instr_count); end
    tick();
    reset = 1'b1; prog_we = 1'b0;
    tick();
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL reset_idle got %b exp %b", outs(), 8'h00); end
  endtask

  task automatic test_program_load();
    int rw_cnt = 0;
    int pl_cnt = 0;
    int busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      prog_we = (i < 3);
      start   = (i < 3);
      opcode  = 8'h01;
      #1;
      rw_cnt   += int'(ram_we);
      pl_cnt   += int'(pc_load);
      busy_cnt += int'(busy);
      tick();
    end
    checks++;
    if (rw_cnt != 3) begin errors++; $display("FAIL prog_ram_we got %0d exp 3", rw_cnt); end
    checks++;
    if (pl_cnt != 3) begin errors++; $display("FAIL prog_pc_load got %0d exp 3", pl_cnt); end
    checks++;
    if (busy_cnt != 0) begin errors++; $display("FAIL prog_busy got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_alu();
    // expected outs per cycle 1..7 after the start pulse
    logic [7:0] exp_tab [1:7];
    exp_tab[1] = 8'b0000_0100;  // FETCH
    exp_tab[2] = 8'b0110_0100;  // LOAD_OPS
    exp_tab[3] = 8'b0000_0100;  // EXEC
    exp_tab[4] = 8'b0001_0100;  // WRITE
    exp_tab[5] = 8'b1000_0100;  // ADVANCE
    exp_tab[6] = 8'b0000_0100;  // FETCH
    exp_tab[7] = 8'b0110_0100;  // LOAD_OPS
    do_reset();
    opcode = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (outs() !== exp_tab[c]) begin
        errors++; $display("FAIL alu_cycle%0d got %b exp %b", c, outs(), exp_tab[c]);
      end
      if (c == 6) begin
        checks++;
        if (instr_count !== 16'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", instr_count); end
      end
      tick();
    end
    // now in EXEC of the second instruction: reset asynchronously
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'h00 || instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_mid_exec got %b/%0d exp 00000000/0", outs(), instr_count);
    end
    tick();
    reset = 1'b1;
    tick();
    prog_we = 1'b1;
    #1;
    checks++;
    if (outs() !== 8'b1000_1000) begin errors++; $display("FAIL reset_to_idle got %b exp 10001000", outs()); end
    prog_we = 1'b0;
  endtask

  task automatic test_nop_hlt();
    int pl_cnt = 0;
    do_reset();
    opcode = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pl_cnt += int'(pc_load);
    opcode = 8'hFF;
    tick();
    pl_cnt += int'(pc_load);
    tick();
    checks++;
    if (pl_cnt != 1) begin errors++; $display("FAIL nop_pc_load got %0d exp 1", pl_cnt); end
    checks++;
    if (outs() !== 8'b0000_0010 || instr_count !== 16'd2) begin
      errors++; $display("FAIL hlt_state got %b/%0d exp 00000010/2", outs(), instr_count);
    end
    for (int i = 0; i < 6; i++) begin
      start = i[0]; prog_we = i[1];
      tick();
    end
    start = 1'b0; prog_we = 1'b1;
    #1;
    checks++;
    if (outs() !== 8'b0000_0010 || instr_count !== 16'd2) begin
      errors++; $display("FAIL hlt_sticky got %b/%0d exp 00000010/2", outs(), instr_count);
    end
    prog_we = 1'b0;
  endtask

  task automatic test_illegal();
    logic [7:0] seen = 8'h00;
    do_reset();
    opcode = 8'h80; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (outs() !== 8'b0000_0001) begin errors++; $display("FAIL illegal_err got %b exp 00000001", outs()); end
    for (int i = 0; i < 6; i++) begin
      start = i[0]; prog_we = i[1]; opcode = 8'h01;
      #1;
      seen |= outs();
      tick();
    end
    start = 1'b0; prog_we = 1'b0;
    checks++;
    if (seen !== 8'b0000_0001 || instr_count !== 16'd0) begin
      errors++; $display("FAIL illegal_sticky got %b/%0d exp 00000001/0", seen, instr_count);
    end
  endtask

`ifdef CU_SINGLE_STEP_EN
  task automatic test_single_step();
    int pl_cnt = 0;
    do_reset();
    opcode = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      pl_cnt += int'(pc_load);
    end
    checks++;
    if (pl_cnt != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL step_hold got %0d/%b exp 0/1", pl_cnt, busy);
    end
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      pl_cnt += int'(pc_load);
    end
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pl_cnt += int'(pc_load);
    end
    checks++;
    if (pl_cnt != 1 || instr_count !== 16'd2) begin
      errors++; $display("FAIL step_release got %0d/%0d exp 1/2", pl_cnt, instr_count);
    end
  endtask
`else
  task automatic test_step_ignored();
    int pl_cnt = 0;
    do_reset();
    opcode = 8'h00; start = 1'b1; step = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pl_cnt += int'(pc_load);
      tick();
    end
    checks++;
    if (pl_cnt != 3 || instr_count !== 16'd3) begin
      errors++; $display("FAIL nop_loop got %0d/%0d exp 3/3", pl_cnt, instr_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_program_load();
    test_alu();
    test_nop_hlt();
    test_illegal();
`ifdef CU_SINGLE_STEP_EN
    test_single_step();
`else
    test_step_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
